// File: rtl/stream_downsize_arbiter_pkg.sv
// Shared types and the round-robin pick used by the downsizer arbiter and
// other shared-resource controllers.
package stream_downsize_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  localparam int unsigned RR_MAX_SRC = 32;

  // First set request after 'last', wrapping modulo n; returns 'last' when none is set.
  function automatic int unsigned rr_pick(input logic [RR_MAX_SRC-1:0] req,
                                          input int unsigned           last,
                                          input int unsigned           n);
    int unsigned idx;
    logic        found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_SRC; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if ((k <= n) && !found && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/stream_rr_arbiter.sv
// Round-robin requester pick with the last-grant pointer; the pointer only
// advances when the owner of the current grant reports completion.
module stream_rr_arbiter
  import stream_downsize_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req_i,
  input  logic             update_i,
  input  logic [SRC_W-1:0] grant_i,
  output logic [SRC_W-1:0] pick_o
);

  logic [SRC_W-1:0]      last_grant_q, last_grant_d;
  logic [RR_MAX_SRC-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[N_SRC-1:0]  = req_i;
    pick_o              = SRC_W'(rr_pick(req_ext, 32'(last_grant_q), N_SRC));
    last_grant_d        = update_i ? grant_i : last_grant_q;
  end

  // Reset to the highest index so the first search starts at source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_W'(N_SRC - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/stream_downsize_arbiter.sv
// Packet-level round-robin arbiter feeding one downsizer through a single
// registered output stage, tagging every beat with its source index.
module stream_downsize_arbiter
  import stream_downsize_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned T_DATA_RATIO = 2,
  parameter int unsigned N_SRC        = 4,
  localparam int unsigned SRC_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [N_SRC-1:0][T_DATA_RATIO-1:0],
  input  logic [N_SRC-1:0]        s_last_i,
  input  logic [N_SRC-1:0]        s_valid_i,
  output logic [N_SRC-1:0]        s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [SRC_W-1:0]        m_src_o,
  output logic                    busy_o
);

  arb_state_e              state_q, state_d;
  logic [SRC_W-1:0]        grant_q, grant_d, pick;
  logic                    out_ready, accept, pkt_done;
  logic [T_DATA_WIDTH-1:0] m_data_q [T_DATA_RATIO-1:0];
  logic                    m_valid_q, m_last_q;
  logic [SRC_W-1:0]        m_src_q;

  assign out_ready = !m_valid_q || m_ready_i;

  stream_rr_arbiter #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (s_valid_i),
    .update_i (pkt_done),
    .grant_i  (grant_q),
    .pick_o   (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // The grant is held until the granted source's last beat is taken, even if it stalls.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    s_ready_o = '0;
    accept    = 1'b0;
    pkt_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|s_valid_i) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_ready_o[grant_q] = out_ready;
        accept             = s_valid_i[grant_q] && out_ready;
        if (accept && s_last_i[grant_q]) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_src_q   <= '0;
      m_data_q  <= '{default: '0};
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_last_q  <= s_last_i[grant_q];
      m_src_q   <= grant_q;
      m_data_q  <= s_data_i[grant_q];
    end else if (m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_valid_o = m_valid_q;
  assign m_src_o   = m_src_q;
  assign busy_o    = (state_q == BUSY);

endmodule

// File: tb/tb_stream_downsize_arbiter.sv
// Directed bench for stream_downsize_arbiter: per-scenario tasks drive the
// sources cycle by cycle and compare against hand-derived beat orders.
module tb_stream_downsize_arbiter;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data [N-1:0][1:0];
  logic [N-1:0] s_last, s_valid, s_ready;
  logic [7:0] m_data [1:0];
  logic       m_last, m_valid, m_ready, busy;
  logic [1:0] m_src;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_downsize_arbiter #(.T_DATA_WIDTH(8), .T_DATA_RATIO(2), .N_SRC(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_src_o(m_src), .busy_o(busy)
  );

  int tot[N];
  int ptr[N];
  int plen[N];
  logic [N-1:0] vmask [64];
  logic rdy_sched [64];
  logic h_busy [64];
  logic h_mvalid [64];
  logic h_last [64];
  logic [N-1:0] h_sready [64];
  logic [1:0] h_src [64];
  logic [7:0] h_d0 [64];
  logic [7:0] h_d1 [64];
  int o_src[$];
  int o_last[$];
  logic [7:0] o_d0[$];
  logic [7:0] o_d1[$];

  function automatic logic [7:0] word(int s, int b, int w);
    return 8'(s * 64 + b * 2 + w);
  endfunction

  task automatic clear_tb();
    for (int s = 0; s < N; s++) begin
      tot[s] = 0; ptr[s] = 0; plen[s] = 1;
    end
    for (int c = 0; c < 64; c++) begin
      vmask[c] = '1; rdy_sched[c] = 1'b1;
    end
    o_src.delete(); o_last.delete(); o_d0.delete(); o_d1.delete();
  endtask

  task automatic drive(int c);
    for (int s = 0; s < N; s++) begin
      if (ptr[s] < tot[s]) begin
        s_valid[s]   = vmask[c][s];
        s_last[s]    = ((ptr[s] % plen[s]) == plen[s] - 1);
        s_data[s][0] = word(s, ptr[s], 0);
        s_data[s][1] = word(s, ptr[s], 1);
      end else begin
        s_valid[s]   = 1'b0;
        s_last[s]    = 1'b0;
        s_data[s][0] = '0;
        s_data[s][1] = '0;
      end
    end
    m_ready = rdy_sched[c];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = '0; s_last = '0; m_ready = 1'b0;
    for (int s = 0; s < N; s++) begin
      s_data[s][0] = '0; s_data[s][1] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic run(int ncyc);
    logic [N-1:0] hs;
    for (int c = 0; c < ncyc; c++) begin
      drive(c);
      @(negedge clk);
      h_busy[c] = busy; h_mvalid[c] = m_valid; h_last[c] = m_last;
      h_sready[c] = s_ready; h_src[c] = m_src; h_d0[c] = m_data[0]; h_d1[c] = m_data[1];
      hs = s_valid & s_ready;
      if (m_valid && m_ready) begin
        o_src.push_back(int'(m_src)); o_last.push_back(int'(m_last));
        o_d0.push_back(m_data[0]); o_d1.push_back(m_data[1]);
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) if (hs[s]) ptr[s]++;
    end
  endtask

  task automatic test_reset();
    s_valid = '1; s_last = '1; m_ready = 1'b1;
    @(posedge clk);
    #1;
    if ({m_valid, m_last, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000", {m_valid, m_last, busy});
    end
    checks++;
    if (m_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", m_src); end
    checks++;
    if ({m_data[1], m_data[0]} !== 16'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0000", {m_data[1], m_data[0]});
    end
    checks++;
    if (s_ready !== 4'b0000) begin failures++; $display("FAIL reset_sready got=%b exp=0000", s_ready); end
    checks++;
    do_reset();
  endtask

  task automatic test_single_src();
    logic exp_busy [6];
    exp_busy = '{0, 1, 1, 1, 0, 0};
    clear_tb(); do_reset();
    tot[1] = 3; plen[1] = 3;
    run(8);
    for (int c = 0; c < 6; c++) begin
      if (h_busy[c] !== exp_busy[c]) begin
        failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, h_busy[c], exp_busy[c]);
      end
      checks++;
    end
    if (h_sready[0] !== 4'b0000 || h_sready[1] !== 4'b0010) begin
      failures++; $display("FAIL single_sready got=%b,%b exp=0000,0010", h_sready[0], h_sready[1]);
    end
    checks++;
    if (h_mvalid[1] !== 1'b0 || h_mvalid[2] !== 1'b1) begin
      failures++; $display("FAIL single_latency got=%b%b exp=01", h_mvalid[1], h_mvalid[2]);
    end
    checks++;
    if (o_src.size() != 3) begin
      failures++; $display("FAIL single_count got=%0d exp=3", o_src.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (o_src[k] != 1 || o_d0[k] !== word(1, k, 0) || o_d1[k] !== word(1, k, 1) ||
            o_last[k] != int'(k == 2)) begin
          failures++;
          $display("FAIL single_beat k=%0d got src=%0d d=%h%h last=%0d exp src=1 d=%h%h last=%0d",
                   k, o_src[k], o_d1[k], o_d0[k], o_last[k], word(1, k, 1), word(1, k, 0), int'(k == 2));
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_contention();
    int pkt, s, b;
    clear_tb(); do_reset();
    for (int i = 0; i < N; i++) begin tot[i] = 4; plen[i] = 2; end
    run(40);
    if (o_src.size() != 16) begin
      failures++; $display("FAIL contention_count got=%0d exp=16", o_src.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        pkt = k / 2; s = pkt % 4; b = (pkt / 4) * 2 + k % 2;
        if (o_src[k] != s || o_d0[k] !== word(s, b, 0) || o_last[k] != (k % 2)) begin
          failures++;
          $display("FAIL contention_beat k=%0d got src=%0d d0=%h last=%0d exp src=%0d d0=%h last=%0d",
                   k, o_src[k], o_d0[k], o_last[k], s, word(s, b, 0), k % 2);
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_backpressure();
    clear_tb(); do_reset();
    tot[1] = 4; plen[1] = 4;
    for (int c = 3; c <= 7; c++) rdy_sched[c] = 1'b0;
    run(14);
    for (int c = 3; c <= 7; c++) begin
      if (h_mvalid[c] !== 1'b1 || h_d0[c] !== word(1, 1, 0) || h_d1[c] !== word(1, 1, 1) ||
          h_src[c] !== 2'd1 || h_last[c] !== 1'b0 || h_sready[c] !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold c=%0d got v=%b d=%h%h src=%0d last=%b rdy=%b exp v=1 d=%h%h src=1 last=0 rdy=0000",
                 c, h_mvalid[c], h_d1[c], h_d0[c], h_src[c], h_last[c], h_sready[c],
                 word(1, 1, 1), word(1, 1, 0));
      end
      checks++;
    end
    if (h_sready[8] !== 4'b0010) begin failures++; $display("FAIL bp_resume got=%b exp=0010", h_sready[8]); end
    checks++;
    if (o_src.size() != 4) begin
      failures++; $display("FAIL bp_count got=%0d exp=4", o_src.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_src[k] != 1 || o_d0[k] !== word(1, k, 0) || o_d1[k] !== word(1, k, 1) ||
            o_last[k] != int'(k == 3)) begin
          failures++; $display("FAIL bp_beat k=%0d got d0=%h exp d0=%h", k, o_d0[k], word(1, k, 0));
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_sticky();
    int exp_s [4];
    int exp_b [4];
    exp_s = '{2, 2, 2, 0};
    exp_b = '{0, 1, 2, 0};
    clear_tb(); do_reset();
    tot[2] = 3; plen[2] = 3;
    tot[0] = 1; plen[0] = 1;
    vmask[0] = 4'b1110; vmask[1] = 4'b1110;
    for (int c = 2; c <= 4; c++) vmask[c] = 4'b1011;
    run(14);
    for (int c = 0; c <= 7; c++) begin
      if (h_sready[c][0] !== 1'b0) begin failures++; $display("FAIL sticky_src0_ready c=%0d got=1 exp=0", c); end
      checks++;
    end
    for (int c = 1; c <= 6; c++) begin
      if (h_busy[c] !== 1'b1) begin failures++; $display("FAIL sticky_busy c=%0d got=0 exp=1", c); end
      checks++;
    end
    if (h_sready[8] !== 4'b0001) begin failures++; $display("FAIL sticky_next got=%b exp=0001", h_sready[8]); end
    checks++;
    if (o_src.size() != 4) begin
      failures++; $display("FAIL sticky_count got=%0d exp=4", o_src.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_src[k] != exp_s[k] || o_d0[k] !== word(exp_s[k], exp_b[k], 0) || o_last[k] != int'(k >= 2)) begin
          failures++;
          $display("FAIL sticky_beat k=%0d got src=%0d d0=%h exp src=%0d d0=%h",
                   k, o_src[k], o_d0[k], exp_s[k], word(exp_s[k], exp_b[k], 0));
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic exp_busy [9];
    int   exp_s [4];
    exp_busy = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    exp_s    = '{0, 3, 0, 3};
    clear_tb(); do_reset();
    tot[0] = 2; plen[0] = 1;
    tot[3] = 2; plen[3] = 1;
    run(12);
    for (int c = 0; c < 9; c++) begin
      if (h_busy[c] !== exp_busy[c]) begin
        failures++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, h_busy[c], exp_busy[c]);
      end
      checks++;
    end
    if (h_sready[1] !== 4'b0001 || h_sready[3] !== 4'b1000 || h_sready[5] !== 4'b0001 || h_sready[7] !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_sready got=%b,%b,%b,%b exp=0001,1000,0001,1000",
               h_sready[1], h_sready[3], h_sready[5], h_sready[7]);
    end
    checks++;
    if (o_src.size() != 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp=4", o_src.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_src[k] != exp_s[k] || o_d0[k] !== word(exp_s[k], k / 2, 0) || o_last[k] != 1) begin
          failures++;
          $display("FAIL b2b_beat k=%0d got src=%0d d0=%h exp src=%0d d0=%h",
                   k, o_src[k], o_d0[k], exp_s[k], word(exp_s[k], k / 2, 0));
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_reset_mid_packet();
    int exp_s [4];
    int exp_b [4];
    exp_s = '{0, 1, 1, 1};
    exp_b = '{0, 0, 1, 2};
    clear_tb(); do_reset();
    tot[1] = 3; plen[1] = 3;
    run(3);
    if (m_valid !== 1'b1 || m_data[0] !== word(1, 1, 0)) begin
      failures++; $display("FAIL midrst_pre got v=%b d0=%h exp v=1 d0=%h", m_valid, m_data[0], word(1, 1, 0));
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if ({m_valid, m_last, busy} !== 3'b000 || m_src !== 2'd0 || {m_data[1], m_data[0]} !== 16'h0 ||
        s_ready !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_clear got v=%b l=%b busy=%b src=%0d d=%h rdy=%b exp all zero",
               m_valid, m_last, busy, m_src, {m_data[1], m_data[0]}, s_ready);
    end
    checks++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_tb();
    tot[1] = 3; plen[1] = 3;
    tot[0] = 1; plen[0] = 1;
    run(12);
    if (o_src.size() != 4) begin
      failures++; $display("FAIL midrst_count got=%0d exp=4", o_src.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_src[k] != exp_s[k] || o_d0[k] !== word(exp_s[k], exp_b[k], 0)) begin
          failures++;
          $display("FAIL midrst_beat k=%0d got src=%0d d0=%h exp src=%0d d0=%h",
                   k, o_src[k], o_d0[k], exp_s[k], word(exp_s[k], exp_b[k], 0));
        end
        checks++;
      end
    end
    checks++;
  endtask

  initial begin
    s_valid = '0; s_last = '0; m_ready = 1'b0;
    for (int s = 0; s < N; s++) begin
      s_data[s][0] = '0; s_data[s][1] = '0;
    end
    test_reset();
    test_single_src();
    test_contention();
    test_backpressure();
    test_sticky();
    test_back_to_back();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_downsize_arbiter.md
Name: stream_downsize_arbiter

Overview:
Packet-level round-robin arbiter that shares one stream_downsize instance between N_SRC wide-stream requesters. It grants one requester at a time and holds the grant until that requester's last beat is accepted. It multiplexes the granted requester's wide beats into a single registered output stage that feeds the downsizer slave port. A source-index sideband travels with every beat so downstream logic can attribute narrow words to their origin.

Parameters:
T_DATA_WIDTH, 8, width of one narrow word.
T_DATA_RATIO, 2, narrow words per wide beat; must match the downstream downsizer.
N_SRC, 4, number of requesters, 1 or more.
SRC_W, $clog2(N_SRC) clamped to a minimum of 1, width of the source index (localparam).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous reset, active low.
s_data_i  in  [T_DATA_WIDTH-1:0] x [N_SRC-1:0][T_DATA_RATIO-1:0] (unpacked)  wide beat per requester.
s_last_i  in  N_SRC  last-beat flag per requester.
s_valid_i  in  N_SRC  valid per requester.
s_ready_o  out  N_SRC  ready per requester.
m_data_o  out  [T_DATA_WIDTH-1:0] x [T_DATA_RATIO-1:0] (unpacked)  wide beat to the downsizer.
m_last_o  out  1  last flag to the downsizer.
m_valid_o  out  1  valid to the downsizer.
m_ready_i  in  1  ready from the downsizer.
m_src_o  out  SRC_W  source index of the beat on m_data_o.
busy_o  out  1  high while a packet grant is held (state BUSY).

Behaviour:
- Reset: asynchronous clear to state IDLE.
  - m_valid_o=0, m_last_o=0, m_data_o=0, m_src_o=0, busy_o=0, s_ready_o=0.
  - last_grant=N_SRC-1, so the first arbitration favours source 0.
- out_ready = !m_valid_o | m_ready_i. Single-entry output register; full throughput while m_ready_i stays high.
- FSM, two states:
  - IDLE: s_ready_o=0. If any s_valid_i bit is set, grant_q <= the first set index searching last_grant+1, last_grant+2, ... modulo N_SRC. Then state <= BUSY. Otherwise stay in IDLE.
  - BUSY: s_ready_o[grant_q] = out_ready; all other bits are 0.
    - An accepted beat (s_valid_i[grant_q] & out_ready) loads m_data_o, m_last_o and m_src_o=grant_q, and sets m_valid_o=1.
    - If the accepted beat has s_last_i[grant_q]=1: state <= IDLE and last_grant <= grant_q.
- Output register: if there is no accept and m_ready_i=1, then m_valid_o <= 0. m_data_o, m_last_o and m_src_o hold while m_valid_o=1 and m_ready_i=0.
- Latency: arbitration takes 1 cycle (IDLE→BUSY). The first beat appears on m_valid_o one cycle after it is accepted. There is one idle input cycle between packets.
- Grant is sticky: deasserting s_valid_i[grant_q] mid-packet keeps the grant. Other requesters are never served mid-packet, whatever their s_valid_i.
- A single-beat packet (last on first beat) returns to IDLE after one BUSY cycle.
- Fairness: with all sources continuously requesting, grants cycle 0,1,...,N_SRC-1,0. No source waits more than N_SRC-1 packets.
- N_SRC=1: grant is always 0 and m_src_o is constantly 0.
- Reset mid-packet: the packet in flight and the output register content are discarded. Rearbitration restarts from source 0.
- Protocol assumption on sources: AXI-style, data and last stable while valid=1 and ready=0. Arbitration does not depend on a source holding valid in IDLE.

Decomposition:
- Package stream_downsize_pkg holds:
  - typedef enum {IDLE, BUSY} arb_state_e.
  - A function rr_pick(req, last) returning the next index.
- Natural sub-module: stream_rr_arbiter.
  - Combinational round-robin pick plus the last_grant register.
  - Reused by other shared-resource controllers.
- The top level holds the FSM, the data mux and the output register.

Test Plan:
- Single source: src1 sends a 3-beat packet, words {A0,A1},{B0,B1},{C0,C1}, m_ready_i=1 → 3 output beats with m_src_o=1 and m_last_o only on beat 3. busy_o is high for 3 cycles after the 1-cycle arbitration.
- Contention: all 4 sources hold 2-beat packets continuously → m_src_o packet order is 0,1,2,3,0. The packets of different sources never interleave.
- Backpressure: m_ready_i low for 5 cycles mid-packet → m_data_o, m_last_o and m_src_o are stable. s_ready_o[grant] is low, then transfer resumes with no beat lost or duplicated.
- Sticky grant: src2 is granted and drops valid for 3 cycles mid-packet while src0 is valid → src0's s_ready_o stays 0 and src2 completes its packet first.
- Back-to-back single-beat packets on src0 and src3 → alternating grants 0,3,0 with one IDLE cycle between packets.
- Reset mid-packet: rst_n asserted during beat 2 of src1 → all outputs are 0 immediately. After release, src1 and src0 both request and src0 is granted first.
